// File: rtl/seven_segment_mux_counter.sv
// Purpose: prescaled up/down BCD counter with a time-multiplexed 7-segment display driver.
// Latency: bcd/tick/overflow change one edge after the prescaler hits TICK_COUNT-1; display lags digit index/bcd by one edge.
// Backpressure: none; enable stalls the prescaler only, the display scan never stops.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   enable     advance the prescaler
//   up_down    1 = count up, 0 = count down (sampled on the tick edge)
//   clear      synchronous zero of count and prescaler
//   bcd        current count, digit 0 in [3:0]
//   led_out    segments {top, up-right, low-right, bottom, low-left, up-left, middle}, active-high
//   digit_sel  one-hot active-high digit enable
//   tick       one-cycle pulse when the prescaler wraps
//   overflow   one-cycle pulse when the count wraps in either direction
module seven_segment_mux_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_COUNT = 16_000_000,
    parameter int SCAN_COUNT = 16_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    tick,
    output logic                    overflow
);

    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           digit_idx;
    logic                    presc_wrap;
    logic                    scan_wrap;
    logic [4*NUM_DIGITS-1:0] bcd_nxt;
    logic                    count_wrap;
    logic                    carry;
    logic [3:0]              dig;
    logic [3:0]              cur_digit;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign presc_wrap = enable && (presc == PRESC_LAST);
    assign scan_wrap  = (scan_cnt == SCAN_LAST);

    // Ripple carry/borrow across digits; the carry out of the top digit
    // is exactly the all-9 -> all-0 (or all-0 -> all-9) wrap condition.
    always_comb begin
        bcd_nxt = bcd;
        carry   = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = bcd[i*4 +: 4];
            if (carry) begin
                if (up_down) begin
                    if (dig >= 4'd9) begin
                        bcd_nxt[i*4 +: 4] = 4'd0;
                    end else begin
                        bcd_nxt[i*4 +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0 || dig > 4'd9) begin
                        bcd_nxt[i*4 +: 4] = 4'd9;
                    end else begin
                        bcd_nxt[i*4 +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        count_wrap = carry;
    end

    // Digit mux written as a compare loop so an out-of-range index
    // (only possible for non-power-of-two digit counts) never slices past bcd.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_digit = bcd[i*4 +: 4];
            end
        end
    end

    // Prescaler, count and pulse outputs; clear wins over a coincident tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            bcd      <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            presc    <= '0;
            bcd      <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tick     <= presc_wrap;
            overflow <= presc_wrap && count_wrap;
            if (presc_wrap) begin
                presc <= '0;
                bcd   <= bcd_nxt;
            end else if (enable) begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Display scan runs free of enable and clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    // Select and segments come from the same index in the same edge, so they
    // always describe the same digit; reset state shows digit 0 as '0'.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_sel <= NUM_DIGITS'(1);
            led_out   <= 7'b1111110;
        end else begin
            digit_sel <= NUM_DIGITS'(1) << digit_idx;
            led_out   <= seg7(cur_digit);
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Purpose: directed self-checking bench for seven_segment_mux_counter (2 digits, tick every 4, scan every 2).
// Latency: expects bcd/tick one edge after prescaler reaches 3, display one edge behind index.
// Backpressure: n/a; all inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seven_segment_mux_counter;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       up_down;
    logic       clear;
    logic [7:0] bcd;
    logic [6:0] led_out;
    logic [1:0] digit_sel;
    logic       tick;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cnt   = 0;
    int edges = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seven_segment_mux_counter #(
        .NUM_DIGITS(2),
        .TICK_COUNT(4),
        .SCAN_COUNT(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .up_down   (up_down),
        .clear     (clear),
        .bcd       (bcd),
        .led_out   (led_out),
        .digit_sel (digit_sel),
        .tick      (tick),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; drives the expected scan position.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'((v % 100) / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // With SCAN_COUNT=2 the index moves every 2 edges and the outputs trail by one.
    task automatic chk_scan(input string tag);
        int         d;
        logic [7:0] b;
        logic [3:0] nib;
        d   = (edges == 0) ? 0 : (((edges - 1) >> 1) & 1);
        b   = to_bcd(cnt);
        nib = (d == 0) ? b[3:0] : b[7:4];
        chk({tag, "_sel"}, 32'(digit_sel), 32'(2'b01 << d));
        chk({tag, "_led"}, 32'(led_out), 32'(seg_tab[nib]));
    endtask

    task automatic do_tick(input int nv, input bit ovf, input string tag);
        cyc(3);
        chk({tag, "_tick_lo"}, 32'(tick), 32'd0);
        chk({tag, "_ovf_lo"}, 32'(overflow), 32'd0);
        chk({tag, "_bcd_hold"}, 32'(bcd), 32'(to_bcd(cnt)));
        chk_scan(tag);
        cyc(1);
        chk({tag, "_tick_hi"}, 32'(tick), 32'd1);
        chk({tag, "_bcd_new"}, 32'(bcd), 32'(to_bcd(nv)));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        cnt = nv;
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        up_down = 1'b1;
        clear   = 1'b0;

        // Async reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_led", 32'(led_out), 32'b1111110);
        chk("rst_sel", 32'(digit_sel), 32'b01);
        chk("rst_bcd", 32'(bcd), 32'h00);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        cyc(1);
        reset_n = 1'b1;

        // Prescaler must hold with enable low.
        cyc(2);
        chk("idle_tick", 32'(tick), 32'd0);
        chk("idle_bcd", 32'(bcd), 32'h00);

        // Full up count through the 99 -> 00 wrap.
        enable  = 1'b1;
        up_down = 1'b1;
        for (int k = 1; k <= 100; k++) do_tick(k % 100, k == 100, "up");
        for (int k = 1; k <= 10; k++) do_tick(k, 1'b0, "up2");

        // Down from 10 through 00 -> 99.
        up_down = 1'b0;
        for (int v = 9; v >= 0; v--) do_tick(v, 1'b0, "dn");
        do_tick(99, 1'b1, "dn_wrap");

        // Enable drop at prescaler=2 stretches the tick by 3 cycles.
        cyc(2);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("hold_tick", 32'(tick), 32'd0);
            chk("hold_bcd", 32'(bcd), 32'h99);
        end
        enable = 1'b1;
        cyc(1);
        chk("resume_tick_lo", 32'(tick), 32'd0);
        cyc(1);
        chk("resume_tick_hi", 32'(tick), 32'd1);
        chk("resume_bcd", 32'(bcd), 32'h98);
        cnt = 98;

        // Clear on the same edge as the 99 -> 00 tick.
        up_down = 1'b1;
        do_tick(99, 1'b0, "pre_clr");
        cyc(3);
        clear = 1'b1;
        cyc(1);
        chk("clr_bcd", 32'(bcd), 32'h00);
        chk("clr_tick", 32'(tick), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        clear = 1'b0;
        cnt = 0;
        do_tick(1, 1'b0, "post_clr");

        // Count to 37 and watch the display alternate.
        for (int v = 2; v <= 37; v++) do_tick(v, 1'b0, "to37");
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("scan37_bcd", 32'(bcd), 32'h37);
            chk_scan("scan37");
        end

        // Reset mid-count with the prescaler about to wrap.
        enable = 1'b1;
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_bcd", 32'(bcd), 32'h00);
        chk("mrst_tick", 32'(tick), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        chk("mrst_sel", 32'(digit_sel), 32'b01);
        chk("mrst_led", 32'(led_out), 32'b1111110);
        cyc(1);
        chk("mrst_tick_edge", 32'(tick), 32'd0);
        chk("mrst_ovf_edge", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cnt = 0;
        do_tick(1, 1'b0, "after_rst");
        do_tick(2, 1'b0, "after_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
